// File: rtl/stream_pkg.sv
// Shared stream constants: FSM state encoding, LFSR taps and default seed.
// Used by rand_source and its companion backpressure sink.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SEND = 2'd2
    } stream_state_e;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    // One step of the right-shifting 8-bit Galois LFSR.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Galois LFSR. Loads seed on rst and advances one step per step pulse.
module lfsr8
    import stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    // Hold the register, reload the seed on reset, advance once per step pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, regardless of statement order.
        if (rst) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/rand_source.sv
// Valid/ready/last packet source with pseudo-random idle gaps between beats.
// Build option RAND_SOURCE_GAP_EN: when defined, gap lengths come from an
// lfsr8 instance; when undefined, every gap is zero and beats are back-to-back.
module rand_source
    import stream_pkg::*;
#(
    parameter int         LEN     = 8,
    parameter int         PKT_LEN = 4,
    parameter int         GAP_W   = 3,
    parameter logic [7:0] SEED    = DEFAULT_SEED
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           ready_in,
    output logic           valid_out,
    output logic [LEN-1:0] data,
    output logic           last,
    output logic [7:0]     pkt_cnt
);

    localparam int               IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

    stream_state_e    state;
    logic [IDX_W-1:0] beat_idx;
    logic [IDX_W-1:0] idx_next;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] g;
    logic             xfer;

    assign xfer     = valid_out && ready_in;
    assign idx_next = (beat_idx == IDX_LAST) ? '0 : beat_idx + 1'b1;

`ifdef RAND_SOURCE_GAP_EN
    logic       load_g;
    logic [7:0] lfsr_q;

    // A new gap value is consumed when leaving IDLE or after each transfer
    // that keeps generating; the LFSR steps exactly on those cycles.
    assign load_g = en && ((state == IDLE) || ((state == SEND) && xfer));

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (load_g),
        .seed (SEED),
        .q    (lfsr_q)
    );

    assign g = lfsr_q[GAP_W-1:0];

    if (GAP_W < 8) begin : g_lfsr_hi
        logic unused_lfsr_hi;
        assign unused_lfsr_hi = ^lfsr_q[7:GAP_W];
    end
`else
    // Without the LFSR every gap is zero, so GAP is never entered.
    assign g = '0;

    logic unused_seed;
    assign unused_seed = ^SEED;
`endif

    // Handshake FSM with registered valid/data/last and the packet counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            data      <= '0;
            last      <= 1'b0;
            beat_idx  <= '0;
            gap_cnt   <= '0;
            pkt_cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        if (g == '0) begin
                            state     <= SEND;
                            valid_out <= 1'b1;
                            last      <= (beat_idx == IDX_LAST);
                        end else begin
                            state   <= GAP;
                            gap_cnt <= g - 1'b1;
                        end
                    end
                end

                GAP: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (gap_cnt == '0) begin
                        state     <= SEND;
                        valid_out <= 1'b1;
                        last      <= (beat_idx == IDX_LAST);
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                SEND: begin
                    // en is only looked at once the presented beat has gone.
                    if (xfer) begin
                        data     <= data + 1'b1;
                        beat_idx <= idx_next;
                        if (last) begin
                            pkt_cnt <= pkt_cnt + 8'd1;
                        end
                        if (!en) begin
                            state     <= IDLE;
                            valid_out <= 1'b0;
                            last      <= 1'b0;
                        end else if (g == '0) begin
                            last <= (idx_next == IDX_LAST);
                        end else begin
                            state     <= GAP;
                            valid_out <= 1'b0;
                            last      <= 1'b0;
                            gap_cnt   <= g - 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    valid_out <= 1'b0;
                    last      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_source.sv
// Directed bench for rand_source: back-to-back stream, backpressure, en drop
// while stalled, mid-packet reset, LEN/pkt_cnt wrap and PKT_LEN=1. With
// RAND_SOURCE_GAP_EN defined it instead checks gap lengths against an LFSR model.
module tb_rand_source;

    logic       clk = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    // main instance: LEN=8, PKT_LEN=4
    logic       rst, en, ready;
    logic       valid, last;
    logic [7:0] data, pkt;

    // wrap instance: LEN=4, PKT_LEN=3
    logic       w_rst, w_en, w_ready;
    logic       w_valid, w_last;
    logic [3:0] w_data;
    logic [7:0] w_pkt;

    // single-beat packets: PKT_LEN=1
    logic       o_rst, o_en, o_ready;
    logic       o_valid, o_last;
    logic [7:0] o_data, o_pkt;

    always #5 clk = ~clk;

    rand_source #(.LEN(8), .PKT_LEN(4), .GAP_W(3), .SEED(8'hA5)) u_dut (
        .clk(clk), .rst(rst), .en(en), .ready_in(ready),
        .valid_out(valid), .data(data), .last(last), .pkt_cnt(pkt)
    );

    rand_source #(.LEN(4), .PKT_LEN(3), .GAP_W(3), .SEED(8'hA5)) u_wrap (
        .clk(clk), .rst(w_rst), .en(w_en), .ready_in(w_ready),
        .valid_out(w_valid), .data(w_data), .last(w_last), .pkt_cnt(w_pkt)
    );

    rand_source #(.LEN(8), .PKT_LEN(1), .GAP_W(3), .SEED(8'hA5)) u_one (
        .clk(clk), .rst(o_rst), .en(o_en), .ready_in(o_ready),
        .valid_out(o_valid), .data(o_data), .last(o_last), .pkt_cnt(o_pkt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef RAND_SOURCE_GAP_EN
        logic [7:0] m;
        int         g;
        int         idle;
`endif
        rst = 1'b1;   en = 1'b0;   ready = 1'b0;
        w_rst = 1'b1; w_en = 1'b0; w_ready = 1'b0;
        o_rst = 1'b1; o_en = 1'b0; o_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", valid, 1'b0);
        check("rst_data",  data,  8'd0);
        check("rst_last",  last,  1'b0);
        check("rst_pkt",   pkt,   8'd0);

`ifdef RAND_SOURCE_GAP_EN
        // Gap lengths follow the low 3 bits of the reference LFSR sequence.
        rst = 1'b0; en = 1'b1; ready = 1'b1;
        m = 8'hA5;
        for (int n = 0; n < 16; n++) begin
            g = int'(m[2:0]);
            m = {1'b0, m[7:1]} ^ (m[0] ? 8'hB8 : 8'h00);
            idle = 0;
            @(negedge clk);
            while (!valid && idle < 20) begin
                idle++;
                @(negedge clk);
            end
            check("gap_len",  idle,  g);
            check("gap_data", data,  n);
            check("gap_last", last,  (n % 4) == 3);
        end
`else
        // Back-to-back stream from reset.
        rst = 1'b0; en = 1'b1; ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("b2b_valid", valid, 1'b1);
            check("b2b_data",  data,  k);
            check("b2b_last",  last,  (k % 4) == 3);
            check("b2b_pkt",   pkt,   k / 4);
        end

        // Backpressure on a mid-packet beat (index 2).
        @(negedge clk);
        check("pre_stall_data", data, 8'd10);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", valid, 1'b1);
            check("stall_data",  data,  8'd10);
            check("stall_last",  last,  1'b0);
        end
        ready = 1'b1;
        @(negedge clk);
        check("post_stall_data", data, 8'd11);
        check("post_stall_last", last, 1'b1);
        check("post_stall_pkt",  pkt,  8'd2);

        // en dropped while the beat is stalled: beat must stay until taken.
        ready = 1'b0; en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("endrop_valid", valid, 1'b1);
            check("endrop_data",  data,  8'd11);
            check("endrop_last",  last,  1'b1);
        end
        ready = 1'b1;
        @(negedge clk);
        check("idle_valid", valid, 1'b0);
        check("idle_pkt",   pkt,   8'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_hold", valid, 1'b0);
        end
        en = 1'b1;
        @(negedge clk);
        check("resume_valid", valid, 1'b1);
        check("resume_data",  data,  8'd12);
        check("resume_last",  last,  1'b0);

        // Reset while presenting beat index 2.
        @(negedge clk);
        check("pre_rst_data", data, 8'd13);
        @(negedge clk);
        check("pre_rst_data", data, 8'd14);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", valid, 1'b0);
        check("midrst_pkt",   pkt,   8'd0);
        check("midrst_data",  data,  8'd0);
        check("midrst_last",  last,  1'b0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("after_rst_valid", valid, 1'b1);
            check("after_rst_data",  data,  k);
            check("after_rst_last",  last,  k == 3);
            check("after_rst_pkt",   pkt,   8'd0);
        end

        // Data wraps mod 16, last every third beat, pkt_cnt wraps 255 -> 0.
        w_rst = 1'b0; w_en = 1'b1; w_ready = 1'b1;
        o_rst = 1'b0; o_en = 1'b1; o_ready = 1'b1;
        for (int k = 0; k < 772; k++) begin
            @(negedge clk);
            check("wrap_valid", w_valid, 1'b1);
            check("wrap_data",  w_data,  k % 16);
            check("wrap_last",  w_last,  (k % 3) == 2);
            check("wrap_pkt",   w_pkt,   (k / 3) % 256);
            if (k < 6) begin
                check("one_valid", o_valid, 1'b1);
                check("one_data",  o_data,  k);
                check("one_last",  o_last,  1'b1);
                check("one_pkt",   o_pkt,   k);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
